// File: rtl/add_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : add_sub_pipe
// Description : Single-stage registered adder/subtractor with a valid/ready
//               handshake on both sides and an accepted-transaction counter.
//               MODE selects the datapath at elaboration time:
//                 0 = add only, 1 = subtract only, 2 = per-transaction via sel.
//               Optional build macro ADD_SUB_PIPE_SAT_EN enables signed
//               saturation of overflowing results; without it results wrap.
// Ports       : clk, rst_n (async, active-low)
//               in_valid/in_ready, sel, in0, in1      -- input transaction
//               out_valid/out_ready, result, carry,
//               overflow                              -- registered result
//               op_count                              -- accepted count (16b)
// Revision    : 1.0 - initial release
// ============================================================================
module add_sub_pipe #(
  parameter int WIDTH = 4,
  parameter int MODE  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic [15:0]      op_count
);

  localparam int c_MSB = WIDTH - 1;

  // --------------------------------------------------------------------------
  // Operation select, fixed at elaboration for MODE 0/1
  // --------------------------------------------------------------------------
  logic w_is_sub;

  generate
    if (MODE == 0) begin : g_add_only
      assign w_is_sub = 1'b0;
    end else if (MODE == 1) begin : g_sub_only
      assign w_is_sub = 1'b1;
    end else begin : g_sel
      assign w_is_sub = sel;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_full;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;

  // Zero-extended operands: bit WIDTH is the carry for an add and, because
  // the subtraction underflows only when in0 < in1, the borrow for a subtract.
  assign w_sum  = {1'b0, in0} + {1'b0, in1};
  assign w_diff = {1'b0, in0} - {1'b0, in1};
  assign w_full = w_is_sub ? w_diff : w_sum;

  // Signed overflow: an add overflows when the operand signs agree, a
  // subtract when they differ; in both cases the result sign then differs
  // from in0. The XOR of the operand signs equals w_is_sub exactly in the
  // case that can overflow.
  assign w_ovf = ((in0[c_MSB] ^ in1[c_MSB]) == w_is_sub) &&
                 (w_full[c_MSB] != in0[c_MSB]);

`ifdef ADD_SUB_PIPE_SAT_EN
  // On overflow the true result always has the sign of in0, so in0's sign
  // alone picks the limit: positive in0 -> max positive, negative -> min.
  logic [WIDTH-1:0] w_sat_lim;

  assign w_sat_lim = in0[c_MSB] ? {1'b1, {c_MSB{1'b0}}} : {1'b0, {c_MSB{1'b1}}};
  assign w_res     = w_ovf ? w_sat_lim : w_full[c_MSB:0];
`else
  assign w_res = w_full[c_MSB:0];
`endif

  // --------------------------------------------------------------------------
  // Handshake and output register
  // --------------------------------------------------------------------------
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             carry_q,     carry_d;
  logic             overflow_q,  overflow_d;
  logic [15:0]      op_count_q,  op_count_d;
  logic             w_accept;

  // The output slot is free when empty or being drained this cycle, which
  // lets back-to-back transactions flow at one per cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    op_count_d  = op_count_q;
    if (w_accept) begin
      out_valid_d = 1'b1;
      result_d    = w_res;
      carry_d     = w_full[WIDTH];
      overflow_d  = w_ovf;
      op_count_d  = op_count_q + 16'd1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      op_count_q  <= 16'd0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      op_count_q  <= op_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign op_count  = op_count_q;

endmodule

`default_nettype wire

// File: tb/tb_add_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_sub_pipe
// Description : Self-checking bench for add_sub_pipe (WIDTH=4). Three
//               instances share the input side: MODE 0 (add), MODE 1
//               (subtract) and MODE 2 (sel). Directed vectors with
//               hand-computed results, plus stall, async reset and
//               op_count wrap sequences. Expected results follow the
//               ADD_SUB_PIPE_SAT_EN build macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_sub_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       sel;
  logic [3:0] in0;
  logic [3:0] in1;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_carry, a_overflow;
  logic [3:0] a_result;
  logic [15:0] a_op_count;
  logic       s_in_ready, s_out_valid, s_carry, s_overflow;
  logic [3:0] s_result;
  logic [15:0] s_op_count;
  logic       d_in_ready, d_out_valid, d_carry, d_overflow;
  logic [3:0] d_result;
  logic [15:0] d_op_count;

  int n_tests;
  int n_fail;

  add_sub_pipe #(.WIDTH(4), .MODE(0)) u_add (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .sel(sel), .in0(in0), .in1(in1), .out_valid(a_out_valid),
    .out_ready(out_ready), .result(a_result), .carry(a_carry),
    .overflow(a_overflow), .op_count(a_op_count)
  );

  add_sub_pipe #(.WIDTH(4), .MODE(1)) u_sub (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .sel(sel), .in0(in0), .in1(in1), .out_valid(s_out_valid),
    .out_ready(out_ready), .result(s_result), .carry(s_carry),
    .overflow(s_overflow), .op_count(s_op_count)
  );

  add_sub_pipe #(.WIDTH(4), .MODE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready),
    .sel(sel), .in0(in0), .in1(in1), .out_valid(d_out_valid),
    .out_ready(out_ready), .result(d_result), .carry(d_carry),
    .overflow(d_overflow), .op_count(d_op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] add_r;   // wrapped add result
    logic       add_c;
    logic       add_v;
    logic [3:0] add_s;   // saturated add result
    logic [3:0] sub_r;
    logic       sub_c;
    logic       sub_v;
    logic [3:0] sub_s;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] ea;
    logic [3:0] es;
    logic [3:0] ed;
    logic       edc;
    logic       edv;

    n_tests = 0;
    n_fail  = 0;

    //                sel   a     b     add_r add_c add_v add_s sub_r sub_c sub_v sub_s
    vecs[0] = '{1'b0, 4'h6, 4'h2, 4'h8, 1'b0, 1'b1, 4'h7, 4'h4, 1'b0, 1'b0, 4'h4};
    vecs[1] = '{1'b1, 4'h2, 4'h6, 4'h8, 1'b0, 1'b1, 4'h7, 4'hC, 1'b1, 1'b0, 4'hC};
    vecs[2] = '{1'b0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0, 4'h0, 4'hE, 1'b0, 1'b0, 4'hE};
    vecs[3] = '{1'b1, 4'h8, 4'h8, 4'h0, 1'b1, 1'b1, 4'h8, 4'h0, 1'b0, 1'b0, 4'h0};
    vecs[4] = '{1'b0, 4'h8, 4'h1, 4'h9, 1'b0, 1'b0, 4'h9, 4'h7, 1'b0, 1'b1, 4'h8};
    vecs[5] = '{1'b1, 4'h7, 4'hF, 4'h6, 1'b1, 1'b0, 4'h6, 4'h8, 1'b1, 1'b1, 4'h7};
    vecs[6] = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0};
    vecs[7] = '{1'b1, 4'h5, 4'h3, 4'h8, 1'b0, 1'b1, 4'h7, 4'h2, 1'b0, 1'b0, 4'h2};

    // ---------------- reset state ----------------
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    sel       = 1'b0;
    in0       = 4'h0;
    in1       = 4'h0;
    out_ready = 1'b0;
    #1;
    check("reset_outputs", {d_out_valid, d_result, d_carry, d_overflow}, 7'h00);
    check("reset_op_count", {16'h0, d_op_count}, 32'h0);
    check("reset_in_ready", {31'h0, d_in_ready}, 32'h1);
    tick();
    tick();
    #2 rst_n = 1'b1;
    check("first_edge_in_ready", {31'h0, d_in_ready}, 32'h1);

    // ---------------- stall with out_ready=0 ----------------
    in0 = 4'h3; in1 = 4'h2; sel = 1'b0; in_valid = 1'b1;
    tick();
    check("stall_first", {d_out_valid, d_result, d_carry, d_overflow}, {1'b1, 4'h5, 1'b0, 1'b0});
    check("stall_in_ready", {31'h0, d_in_ready}, 32'h0);
    check("stall_count1", {16'h0, d_op_count}, 32'h1);
    in_valid = 1'b0;
    tick();
    in0 = 4'h1; in1 = 4'h1; sel = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    in0 = 4'h7; in1 = 4'h7; sel = 1'b0; in_valid = 1'b1;
    tick();
    check("stall_held", {d_out_valid, d_result, d_carry, d_overflow}, {1'b1, 4'h5, 1'b0, 1'b0});
    check("stall_in_ready2", {31'h0, d_in_ready}, 32'h0);
    check("stall_count_hold", {16'h0, d_op_count}, 32'h1);
    in_valid = 1'b0;

    // ---------------- async reset mid-hold ----------------
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {d_out_valid, d_result, d_carry, d_overflow}, 7'h00);
    check("async_rst_count", {16'h0, d_op_count}, 32'h0);
    check("async_rst_in_ready", {31'h0, d_in_ready}, 32'h1);
    #1 rst_n = 1'b1;
    tick();
    check("after_rst_no_result", {d_out_valid, d_result}, 5'h00);

    // ---------------- back-to-back vectors, sel alternating ----------------
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = vecs[i].sel;
      in0 = vecs[i].a;
      in1 = vecs[i].b;
      tick();
`ifdef ADD_SUB_PIPE_SAT_EN
      ea = vecs[i].add_s;
      es = vecs[i].sub_s;
`else
      ea = vecs[i].add_r;
      es = vecs[i].sub_r;
`endif
      ed  = vecs[i].sel ? es : ea;
      edc = vecs[i].sel ? vecs[i].sub_c : vecs[i].add_c;
      edv = vecs[i].sel ? vecs[i].sub_v : vecs[i].add_v;
      check($sformatf("mode0_vec%0d", i), {a_out_valid, a_result, a_carry, a_overflow},
            {1'b1, ea, vecs[i].add_c, vecs[i].add_v});
      check($sformatf("mode1_vec%0d", i), {s_out_valid, s_result, s_carry, s_overflow},
            {1'b1, es, vecs[i].sub_c, vecs[i].sub_v});
      check($sformatf("mode2_vec%0d", i), {d_out_valid, d_result, d_carry, d_overflow},
            {1'b1, ed, edc, edv});
      check($sformatf("count_vec%0d", i), {16'h0, d_op_count}, i + 1);
    end
    in_valid = 1'b0;
    tick();
    check("drain_out_valid", {31'h0, d_out_valid}, 32'h0);
    check("drain_count", {16'h0, d_op_count}, 32'h8);

    // ---------------- op_count wrap ----------------
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    in0 = 4'h1; in1 = 4'h1; sel = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    check("count_fffe", {16'h0, d_op_count}, 32'h0000FFFE);
    tick();
    check("count_ffff", {16'h0, d_op_count}, 32'h0000FFFF);
    tick();
    check("count_wrap", {16'h0, d_op_count}, 32'h0);
    check("count_wrap_mode0", {16'h0, a_op_count}, 32'h0);
    in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
